attn_inst_sequencer: RTL and testbench
======================================

# attn_inst_sequencer

Hardware instruction sequencer that drives the `inst` word of the dual-core attention `fullchip`. It replaces bench-driven phase stepping with one parametrised FSM that runs these phases after Q/K memories are loaded: K load, execute, OFIFO-to-pmem drain, and per-row SFP accumulate/normalise. Q-vector count, column count and inter-phase gap are runtime-programmable. Address width is a parameter.

## Interface
- `ADDR_W`, default 4: qkmem/pmem address width. `inst` width is `11+2*ADDR_W`.
- `GAP_W`, default 4: width of the programmable idle-gap count.
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to run a sequence. Ignored while `busy`.
- `abort` in 1: synchronous cancel.
- `n_q` in ADDR_W+1: number of Q vectors to execute, legal range 1..2^ADDR_W.
- `n_col` in ADDR_W+1: number of K columns to load, legal range 1..2^ADDR_W.
- `gap` in GAP_W: idle cycles inserted after the load phase and after the execute phase.
- `ofifo_valid` in 1: OFIFO holds at least one row.
- `inst` out 11+2*ADDR_W: field layout, MSB first: div_ready, acc_ready, ofifo_rd, qkmem_add[ADDR_W], pmem_add[ADDR_W], execute, load, qmem_rd, qmem_wr, kmem_rd, kmem_wr, pmem_rd, pmem_wr.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle pulse on normal completion.
- `cfg_err` out 1: one-cycle pulse when `start` arrives with `n_q==0` or `n_col==0`.

## Operation
- All outputs are registered. Reset value of every output is 0.
- `n_q`, `n_col` and `gap` are latched at an accepted `start`. Later changes to them have no effect on the running sequence.
- qmem_wr and kmem_wr are always 0. pmem_rd is 0 outside the SFP phase.
- IDLE: `inst`=0. On `start` with legal config, go to LOAD. On `start` with illegal config, pulse `cfg_err` and stay in IDLE.
- LOAD runs `n_col`+1 cycles, L0..L`n_col`:
  - load=1 throughout.
  - kmem_rd=1 from L1 onward.
  - qkmem_add=0 at L0 and L1, then increments each cycle, reaching `n_col`-1 at L`n_col`.
- LEND, 1 cycle: load=1, kmem_rd=0, qkmem_add=0.
- LOFF, 1 cycle: all fields 0.
- GAP1: `gap` cycles of all-zero `inst`. Skipped when `gap`=0.
- EXEC runs `n_q` cycles: execute=1, qmem_rd=1, qkmem_add steps 0..`n_q`-1.
- EEND, 1 cycle: all fields 0, qkmem_add=0.
- GAP2: same rules as GAP1.
- DRAIN: counts `n_q` transfers.
  - A transfer cycle has ofifo_rd=1, pmem_wr=1 and pmem_add equal to the transfer index.
  - A transfer is issued in cycle t+1 only if `ofifo_valid`=1 at edge t.
  - Otherwise that cycle is a stall: ofifo_rd=0, pmem_wr=0, pmem_add held.
- DEND, 1 cycle: all fields 0, pmem_add=0.
- SFP (macro-dependent, see Configuration): for each row r in 0..`n_q`-1, a five-cycle micro-sequence with pmem_rd=1 and pmem_add=r:
  - S0: acc=0, div=0.
  - S1, S2: acc=1.
  - S3, S4: acc=0, div=1.
  - pmem_add increments on leaving S4.
- STAIL, 2 cycles: pmem_rd=0, div_ready=1, pmem_add=0.
- DONE: `inst`=0, `done`=1 for one cycle, `busy`=0, return to IDLE.
- `abort` has priority over everything, including `start` in the same cycle. On the next edge `inst`=0, `busy`=0, the FSM is in IDLE, and no `done` pulse is issued.
- If `reset_n` is asserted mid-sequence, all state and outputs clear immediately. No resume.

## Timing
- Accepted `start` at edge t: L0 appears at t+1, `busy`=1 from t+1.
- Total busy cycles with no stalls and SFP enabled: (`n_col`+3) + 2·`gap` + (`n_q`+1) + (`n_q`+1) + 5·`n_q` + 2.
- Each OFIFO stall adds exactly one cycle.
- `done` is asserted in the cycle immediately after the last STAIL cycle (or after DEND when SFP is compiled out).
- `start` during `busy` is dropped and has no queued effect.

## Configuration
- `ATTN_SEQ_SFP_EN` defined: the SFP and STAIL phases are generated, and div_ready/acc_ready are driven as specified.
- `ATTN_SEQ_SFP_EN` undefined:
  - DEND goes directly to DONE.
  - div_ready, acc_ready and pmem_rd are constant 0.
  - Total busy length drops by 5·`n_q`+2.

## Structure
- Package `attn_seq_pkg` holds:
  - the phase enum (IDLE, LOAD, LEND, LOFF, GAP1, EXEC, EEND, GAP2, DRAIN, DEND, SFP, STAIL, DONE);
  - `inst` bit-position localparams as functions of ADDR_W;
  - the SFP micro-step count (5) and tail length (2).
- One sub-module: `attn_sfp_row_fsm`, the S0..S4 micro-sequencer with a row counter and row-done flag. It is instantiated only under `ATTN_SEQ_SFP_EN`.

## Test plan
- Defaults, `n_col`=8, `n_q`=8, `gap`=10, `ofifo_valid` tied 1:
  - exact per-cycle `inst` matches the legacy 8×8 dual-core sequence;
  - `done` arrives 8+3+20+9+9+42 = 91 cycles after `start`.
- `ofifo_valid` low for cycles 2–4 of DRAIN:
  - ofifo_rd/pmem_wr drop for 3 cycles;
  - pmem_add is held at 2 across the stall;
  - `done` is delayed by exactly 3 cycles.
- `n_q`=1, `n_col`=1, `gap`=0:
  - minimal sequence with no GAP states;
  - `done` after 4+2+2+5+2 = 15 cycles.
- `abort` asserted mid-EXEC at qkmem_add=3:
  - `inst`=0 and `busy`=0 on the next edge, no `done` pulse;
  - a new `start` runs a full sequence correctly.
- `start` with `n_q`=0:
  - `cfg_err` pulses, `busy` stays 0;
  - a second `start` during a running sequence is ignored.
- `ADDR_W`=5, `n_q`=32, built without `ATTN_SEQ_SFP_EN`:
  - pmem_add reaches 31;
  - div_ready/acc_ready never assert;
  - `done` directly follows DEND.

Source files
------------

// File: rtl/attn_seq_pkg.sv
// Shared definitions for the attention instruction sequencer: phase encoding,
// inst bit positions (functions of ADDR_W) and SFP micro-sequence lengths.
package attn_seq_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        LOAD  = 4'd1,
        LEND  = 4'd2,
        LOFF  = 4'd3,
        GAP1  = 4'd4,
        EXEC  = 4'd5,
        EEND  = 4'd6,
        GAP2  = 4'd7,
        DRAIN = 4'd8,
        DEND  = 4'd9,
        SFP   = 4'd10,
        STAIL = 4'd11,
        DONE  = 4'd12
    } phase_e;

    localparam int SFP_STEPS = 5;
    localparam int SFP_TAIL  = 2;

    localparam int B_PMEM_WR  = 0;
    localparam int B_PMEM_RD  = 1;
    localparam int B_KMEM_WR  = 2;
    localparam int B_KMEM_RD  = 3;
    localparam int B_QMEM_WR  = 4;
    localparam int B_QMEM_RD  = 5;
    localparam int B_LOAD     = 6;
    localparam int B_EXECUTE  = 7;
    localparam int B_PMEM_ADD = 8;

    function automatic int b_qkmem_add(input int aw);
        return 8 + aw;
    endfunction

    function automatic int b_ofifo_rd(input int aw);
        return 8 + 2 * aw;
    endfunction

    function automatic int b_acc_ready(input int aw);
        return 9 + 2 * aw;
    endfunction

    function automatic int b_div_ready(input int aw);
        return 10 + 2 * aw;
    endfunction

    function automatic int inst_width(input int aw);
        return 11 + 2 * aw;
    endfunction

endpackage

// File: rtl/attn_sfp_row_fsm.sv
// SFP row micro-sequencer: steps S0..S4 per row, row counter, last-row flag.
// Registers hold the step to be issued next; adv moves one step per cycle.
// No backpressure: advances whenever adv is high, clr returns it to S0/row 0.
module attn_sfp_row_fsm
    import attn_seq_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              adv,
    input  logic [ADDR_W:0]   n_q,
    output logic              acc,
    output logic              div,
    output logic [ADDR_W-1:0] row_add,
    output logic              row_done
);

    typedef logic [ADDR_W-1:0] addr_t;
    localparam logic [2:0]    LAST_STEP = 3'(SFP_STEPS - 1);
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

    logic [2:0]      step;
    logic [ADDR_W:0] row;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step     <= '0;
            row      <= '0;
            row_done <= 1'b0;
        end else if (clr) begin
            step     <= '0;
            row      <= '0;
            row_done <= 1'b0;
        end else if (adv) begin
            if (step == LAST_STEP) begin
                step <= '0;
                row  <= row + ONE;
                // flag rises as the final S4 is issued, so the parent leaves after it
                if (row == n_q - ONE)
                    row_done <= 1'b1;
            end else begin
                step <= step + 3'd1;
            end
        end
    end

    assign acc     = (step == 3'd1) || (step == 3'd2);
    assign div     = (step == 3'd3) || (step == 3'd4);
    assign row_add = addr_t'(row);

endmodule

// File: rtl/attn_inst_sequencer.sv
// Phase sequencer driving the fullchip inst word; SFP phase under ATTN_SEQ_SFP_EN.
// Latency: L0 one cycle after accepted start; all outputs registered.
// Backpressure: DRAIN issues a transfer only when ofifo_valid was high the cycle before.
module attn_inst_sequencer
    import attn_seq_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int GAP_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_W:0]       n_q,
    input  logic [ADDR_W:0]       n_col,
    input  logic [GAP_W-1:0]      gap,
    input  logic                  ofifo_valid,
    output logic [11+2*ADDR_W-1:0] inst,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    localparam int IW    = inst_width(ADDR_W);
    localparam int B_QK  = b_qkmem_add(ADDR_W);
    localparam int B_OFR = b_ofifo_rd(ADDR_W);
    localparam int B_ACC = b_acc_ready(ADDR_W);
    localparam int B_DIV = b_div_ready(ADDR_W);
    localparam int CW    = (ADDR_W + 1 > GAP_W) ? ADDR_W + 1 : GAP_W;

    typedef logic [CW-1:0]     cnt_t;
    typedef logic [ADDR_W-1:0] addr_t;
    localparam cnt_t C1 = cnt_t'(1);

    phase_e state, nxt_state;
    cnt_t   cnt, nxt_cnt, nq_r, ncol_r, gap_r, xidx, cm1;
    logic   nxt_err, latch, xfer;
    logic [IW-1:0] nxt_inst;

`ifdef ATTN_SEQ_SFP_EN
    logic          sfp_acc, sfp_div, sfp_row_done;
    addr_t         sfp_row;
    logic [ADDR_W:0] nq_sfp;

    assign nq_sfp = (ADDR_W + 1)'(nq_r);

    attn_sfp_row_fsm #(.ADDR_W(ADDR_W)) u_sfp (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      ((state == IDLE) || (state == DONE)),
        .adv      (nxt_state == SFP),
        .n_q      (nq_sfp),
        .acc      (sfp_acc),
        .div      (sfp_div),
        .row_add  (sfp_row),
        .row_done (sfp_row_done)
    );
`endif

    // Next phase and counter; cnt is the in-phase index (transfers issued in DRAIN)
    always_comb begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
        nxt_err   = 1'b0;
        latch     = 1'b0;
        xfer      = 1'b0;
        xidx      = '0;
        if (!abort) begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (n_q == '0 || n_col == '0) begin
                            nxt_err = 1'b1;
                        end else begin
                            latch     = 1'b1;
                            nxt_state = LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (cnt == ncol_r) nxt_state = LEND;
                    else begin nxt_state = LOAD; nxt_cnt = cnt + C1; end
                end
                LEND: nxt_state = LOFF;
                LOFF: nxt_state = (gap_r != '0) ? GAP1 : EXEC;
                GAP1: begin
                    if (cnt == gap_r - C1) nxt_state = EXEC;
                    else begin nxt_state = GAP1; nxt_cnt = cnt + C1; end
                end
                EXEC: begin
                    if (cnt == nq_r - C1) nxt_state = EEND;
                    else begin nxt_state = EXEC; nxt_cnt = cnt + C1; end
                end
                EEND: nxt_state = (gap_r != '0) ? GAP2 : DRAIN;
                GAP2: begin
                    if (cnt == gap_r - C1) nxt_state = DRAIN;
                    else begin nxt_state = GAP2; nxt_cnt = cnt + C1; end
                end
                DRAIN: begin
                    if (cnt == nq_r) nxt_state = DEND;
                    else begin nxt_state = DRAIN; nxt_cnt = cnt; end
                end
`ifdef ATTN_SEQ_SFP_EN
                DEND:  nxt_state = SFP;
                SFP:   nxt_state = sfp_row_done ? STAIL : SFP;
                STAIL: begin
                    if (cnt == cnt_t'(SFP_TAIL - 1)) nxt_state = DONE;
                    else begin nxt_state = STAIL; nxt_cnt = cnt + C1; end
                end
`else
                DEND:  nxt_state = DONE;
`endif
                default: nxt_state = IDLE;
            endcase
            if (nxt_state == DRAIN) begin
                xidx = nxt_cnt;
                if (ofifo_valid) begin
                    xfer    = 1'b1;
                    nxt_cnt = nxt_cnt + C1;
                end
            end
        end
    end

    assign cm1 = nxt_cnt - C1;

    // inst word for the cycle about to start
    always_comb begin
        nxt_inst = '0;
        case (nxt_state)
            LOAD: begin
                nxt_inst[B_LOAD]            = 1'b1;
                nxt_inst[B_KMEM_RD]         = (nxt_cnt != '0);
                nxt_inst[B_QK +: ADDR_W]    = (nxt_cnt == '0) ? '0 : addr_t'(cm1);
            end
            LEND: nxt_inst[B_LOAD] = 1'b1;
            EXEC: begin
                nxt_inst[B_EXECUTE]         = 1'b1;
                nxt_inst[B_QMEM_RD]         = 1'b1;
                nxt_inst[B_QK +: ADDR_W]    = addr_t'(nxt_cnt);
            end
            DRAIN: begin
                nxt_inst[B_OFR]             = xfer;
                nxt_inst[B_PMEM_WR]         = xfer;
                nxt_inst[B_PMEM_ADD +: ADDR_W] = xfer ? addr_t'(xidx) : inst[B_PMEM_ADD +: ADDR_W];
            end
`ifdef ATTN_SEQ_SFP_EN
            SFP: begin
                nxt_inst[B_PMEM_RD]         = 1'b1;
                nxt_inst[B_ACC]             = sfp_acc;
                nxt_inst[B_DIV]             = sfp_div;
                nxt_inst[B_PMEM_ADD +: ADDR_W] = sfp_row;
            end
            STAIL: nxt_inst[B_DIV] = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            nq_r    <= '0;
            ncol_r  <= '0;
            gap_r   <= '0;
            inst    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            state   <= nxt_state;
            cnt     <= nxt_cnt;
            inst    <= nxt_inst;
            busy    <= (nxt_state != IDLE) && (nxt_state != DONE);
            done    <= (nxt_state == DONE);
            cfg_err <= nxt_err;
            if (latch) begin
                nq_r   <= cnt_t'(n_q);
                ncol_r <= cnt_t'(n_col);
                gap_r  <= cnt_t'(gap);
            end
        end
    end

endmodule

// File: tb/tb_attn_inst_sequencer.sv
// Directed bench for attn_inst_sequencer (ADDR_W=4 and ADDR_W=5 instances).
module tb_attn_inst_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        start_a, abort_a, ofv_a;
    logic [4:0]  nq_a, ncol_a;
    logic [3:0]  gap_a;
    logic [18:0] inst_a;
    logic        busy_a, done_a, err_a;

    logic        start_b, abort_b, ofv_b;
    logic [5:0]  nq_b, ncol_b;
    logic [3:0]  gap_b;
    logic [20:0] inst_b;
    logic        busy_b, done_b, err_b;

    attn_inst_sequencer #(.ADDR_W(4), .GAP_W(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .abort(abort_a),
        .n_q(nq_a), .n_col(ncol_a), .gap(gap_a), .ofifo_valid(ofv_a),
        .inst(inst_a), .busy(busy_a), .done(done_a), .cfg_err(err_a)
    );

    attn_inst_sequencer #(.ADDR_W(5), .GAP_W(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .abort(abort_b),
        .n_q(nq_b), .n_col(ncol_b), .gap(gap_b), .ofifo_valid(ofv_b),
        .inst(inst_b), .busy(busy_b), .done(done_b), .cfg_err(err_b)
    );

    int checks = 0;
    int failures = 0;
    bit sel = 1'b0;
    logic [31:0] obs_inst;
    logic obs_busy, obs_done, obs_err;
    logic [31:0] expq[$];

    always_comb begin
        obs_inst = sel ? 32'(inst_b) : 32'(inst_a);
        obs_busy = sel ? busy_b : busy_a;
        obs_done = sel ? done_b : done_a;
        obs_err  = sel ? err_b  : err_a;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit s, input int nq, input int ncol, input int g);
        if (!sel) begin
            start_a = s; nq_a = 5'(nq); ncol_a = 5'(ncol); gap_a = 4'(g);
        end else begin
            start_b = s; nq_b = 6'(nq); ncol_b = 6'(ncol); gap_b = 4'(g);
        end
    endtask

    task automatic set_ofv(input bit v);
        if (!sel) ofv_a = v;
        else      ofv_b = v;
    endtask

    // args: addr width, div, acc, ofifo_rd, qkmem_add, pmem_add, execute, load, qmem_rd, kmem_rd, pmem_rd, pmem_wr
    function automatic logic [31:0] mk(input int a, input bit dv, input bit ac, input bit ofr,
                                       input int qk, input int pa, input bit ex, input bit ld,
                                       input bit qrd, input bit krd, input bit prd, input bit pwr);
        logic [31:0] v;
        logic [31:0] m;
        m = (32'd1 << a) - 32'd1;
        v = '0;
        v[0] = pwr; v[1] = prd; v[3] = krd; v[5] = qrd; v[6] = ld; v[7] = ex;
        v = v | ((32'(pa) & m) << 8) | ((32'(qk) & m) << (8 + a));
        v[8+2*a]  = ofr;
        v[9+2*a]  = ac;
        v[10+2*a] = dv;
        return v;
    endfunction

    // Expected busy-cycle inst stream; stall_len stalls follow DRAIN cycle stall_from
    task automatic build(input int a, input int nq, input int ncol, input int g,
                         input int stall_from, input int stall_len);
        int idx, c, held;
        expq.delete();
        for (int k = 0; k <= ncol; k++)
            expq.push_back(mk(a, 0, 0, 0, (k == 0) ? 0 : k - 1, 0, 0, 1, 0, (k != 0), 0, 0));
        expq.push_back(mk(a, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        expq.push_back(32'd0);
        for (int k = 0; k < g; k++) expq.push_back(32'd0);
        for (int i = 0; i < nq; i++)
            expq.push_back(mk(a, 0, 0, 0, i, 0, 1, 0, 1, 0, 0, 0));
        expq.push_back(32'd0);
        for (int k = 0; k < g; k++) expq.push_back(32'd0);
        idx = 0; c = 0; held = 0;
        while (idx < nq) begin
            if (c > stall_from && c <= stall_from + stall_len) begin
                expq.push_back(mk(a, 0, 0, 0, 0, held, 0, 0, 0, 0, 0, 0));
            end else begin
                expq.push_back(mk(a, 0, 0, 1, 0, idx, 0, 0, 0, 0, 0, 1));
                held = idx;
                idx++;
            end
            c++;
        end
        expq.push_back(32'd0);
`ifdef ATTN_SEQ_SFP_EN
        for (int r = 0; r < nq; r++) begin
            expq.push_back(mk(a, 0, 0, 0, 0, r, 0, 0, 0, 0, 1, 0));
            expq.push_back(mk(a, 0, 1, 0, 0, r, 0, 0, 0, 0, 1, 0));
            expq.push_back(mk(a, 0, 1, 0, 0, r, 0, 0, 0, 0, 1, 0));
            expq.push_back(mk(a, 1, 0, 0, 0, r, 0, 0, 0, 0, 1, 0));
            expq.push_back(mk(a, 1, 0, 0, 0, r, 0, 0, 0, 0, 1, 0));
        end
        expq.push_back(mk(a, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        expq.push_back(mk(a, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`endif
    endtask

    task automatic run(input string tag, input int a, input int nq, input int ncol, input int g,
                       input int stall_len, input bit intrude, input int exp_total,
                       output int maxpa);
        int len, dstart, nbusy, pa;
        build(a, nq, ncol, g, 2, stall_len);
        len    = expq.size();
        dstart = ncol + 3 + 2 * g + nq + 1;
        nbusy  = 0;
        maxpa  = 0;
        @(negedge clk);
        set_ofv(1'b1);
        set_in(1'b1, nq, ncol, g);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            if (k == 0) set_in(1'b0, 1, 1, 0);
            if (intrude && k == 5) set_in(1'b1, 0, 1, 0);
            if (intrude && k == 6) set_in(1'b0, 1, 1, 0);
            chk({tag, "_inst"}, obs_inst, expq[k]);
            chk({tag, "_busy"}, 32'(obs_busy), 32'd1);
            chk({tag, "_cfg_err"}, 32'(obs_err), 32'd0);
            if (obs_busy) nbusy++;
            pa = int'((obs_inst >> 8) & ((32'd1 << a) - 32'd1));
            if (pa > maxpa) maxpa = pa;
            set_ofv(!(stall_len > 0 && k >= dstart + 2 && k < dstart + 2 + stall_len));
        end
        @(negedge clk);
        set_ofv(1'b1);
        chk({tag, "_done"}, 32'(obs_done), 32'd1);
        chk({tag, "_busy_end"}, 32'(obs_busy), 32'd0);
        chk({tag, "_inst_end"}, obs_inst, 32'd0);
        chk({tag, "_busy_len"}, 32'(nbusy), 32'(exp_total));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(obs_done), 32'd0);
    endtask

    int mp, dn;

    initial begin
        reset_n = 1'b0;
        start_a = 0; abort_a = 0; ofv_a = 1; nq_a = 0; ncol_a = 0; gap_a = 0;
        start_b = 0; abort_b = 0; ofv_b = 1; nq_b = 0; ncol_b = 0; gap_b = 0;
        #12;
        chk("rst_inst", 32'(inst_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_cfg_err", 32'(err_a), 32'd0);
        chk("rst_inst_b", 32'(inst_b), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        sel = 1'b0;
`ifdef ATTN_SEQ_SFP_EN
        run("base8x8", 4, 8, 8, 10, 0, 1'b1, 91, mp);
        run("stall", 4, 8, 8, 10, 3, 1'b0, 94, mp);
        run("min1x1", 4, 1, 1, 0, 0, 1'b0, 15, mp);
`else
        run("base8x8", 4, 8, 8, 10, 0, 1'b1, 49, mp);
        run("stall", 4, 8, 8, 10, 3, 1'b0, 52, mp);
        run("min1x1", 4, 1, 1, 0, 0, 1'b0, 8, mp);
`endif

        // abort in EXEC at qkmem_add=3
        build(4, 8, 8, 10, 2, 0);
        @(negedge clk);
        set_in(1'b1, 8, 8, 10);
        for (int k = 0; k <= 24; k++) begin
            @(negedge clk);
            if (k == 0) set_in(1'b0, 8, 8, 10);
            chk("abort_pre_inst", obs_inst, expq[k]);
        end
        chk("abort_qk", (obs_inst >> 12) & 32'hF, 32'd3);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        chk("abort_inst", obs_inst, 32'd0);
        chk("abort_busy", 32'(obs_busy), 32'd0);
        dn = 0;
        repeat (100) begin
            if (obs_done) dn++;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(dn), 32'd0);
`ifdef ATTN_SEQ_SFP_EN
        run("post_abort", 4, 8, 8, 10, 0, 1'b0, 91, mp);
`else
        run("post_abort", 4, 8, 8, 10, 0, 1'b0, 49, mp);
`endif

        // illegal configurations
        @(negedge clk);
        set_in(1'b1, 0, 8, 10);
        @(negedge clk);
        set_in(1'b0, 0, 8, 10);
        chk("cfg_nq0_err", 32'(obs_err), 32'd1);
        chk("cfg_nq0_busy", 32'(obs_busy), 32'd0);
        @(negedge clk);
        chk("cfg_nq0_err_pulse", 32'(obs_err), 32'd0);
        chk("cfg_nq0_busy2", 32'(obs_busy), 32'd0);
        set_in(1'b1, 8, 0, 10);
        @(negedge clk);
        set_in(1'b0, 8, 0, 10);
        chk("cfg_ncol0_err", 32'(obs_err), 32'd1);
        chk("cfg_ncol0_inst", obs_inst, 32'd0);

        // asynchronous reset mid-sequence
        @(negedge clk);
        set_in(1'b1, 4, 4, 2);
        @(negedge clk);
        set_in(1'b0, 4, 4, 2);
        repeat (5) @(negedge clk);
        chk("mid_rst_busy_before", 32'(obs_busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_inst", obs_inst, 32'd0);
        chk("mid_rst_busy", 32'(obs_busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_no_resume", 32'(obs_busy), 32'd0);

        // wide instance, 32 Q vectors
        sel = 1'b1;
`ifdef ATTN_SEQ_SFP_EN
        run("aw5_nq32", 5, 32, 4, 2, 0, 1'b0, 239, mp);
`else
        run("aw5_nq32", 5, 32, 4, 2, 0, 1'b0, 77, mp);
`endif
        chk("aw5_max_pmem_add", 32'(mp), 32'd31);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
